// File: rtl/video_timing_pkg.sv
// Shared constants, derived totals and FSM state type for the raster timing generator.
package video_timing_pkg;

  // 640x480@60 defaults (800x525 total at 25 MHz)
  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_LOCK_WAIT = 1024;

  localparam int CNT_W = 10;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  typedef enum logic [0:0] {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

endpackage

// File: rtl/video_timing_lock_qualifier.sv
// Counts consecutive locked cycles; lock_ok is high only once the run of
// locked cycles has reached LOCK_WAIT and drops on any unlocked cycle.
module lock_qualifier #(
  parameter int LOCK_WAIT = 1024
) (
  input  logic clk_25MHz,
  input  logic resetn,
  input  logic locked,
  output logic lock_ok
);

  localparam int CW = $clog2(LOCK_WAIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_WAIT - 1);

  logic [CW-1:0] lock_cnt;

  // Streak counter: clears on any unlocked cycle, saturates at the terminal value.
  always_ff @(posedge clk_25MHz) begin
    if (!resetn) begin
      lock_cnt <= '0;
    end else if (!locked) begin
      lock_cnt <= '0;
    end else if (lock_cnt != CNT_LAST) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  assign lock_ok = locked && (lock_cnt == CNT_LAST);

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: waits for a qualified PLL lock, then scans h/v
// counters and emits registered sync, data-enable and coordinate outputs.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   WAIT_LOCK | counters held at (0,0), outputs idle
//   RUN       | counters scanning the raster, outputs decoded
module video_timing
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   LOCK_WAIT = DEF_LOCK_WAIT
) (
  input  logic             clk_25MHz,
  input  logic             resetn,
  input  logic             locked,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic             running
);

  localparam int H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
  // Sync windows kept as int so an end bound of 1024 does not truncate.
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = V_ACTIVE + V_FP + V_SYNC;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic             lock_ok;
  logic             hs_act, vs_act, de_act;

  lock_qualifier #(.LOCK_WAIT(LOCK_WAIT)) u_lock_qualifier (
    .clk_25MHz (clk_25MHz),
    .resetn    (resetn),
    .locked    (locked),
    .lock_ok   (lock_ok)
  );

  // State and raster counter registers.
  always_ff @(posedge clk_25MHz) begin
    if (!resetn) begin
      state <= WAIT_LOCK;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_nxt;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // Next state and counter advance; any lock loss returns to (0,0) immediately.
  always_comb begin
    state_nxt = state;
    h_nxt     = '0;
    v_nxt     = '0;
    case (state)
      WAIT_LOCK: begin
        if (lock_ok) state_nxt = RUN;
      end
      RUN: begin
        if (!lock_ok) begin
          state_nxt = WAIT_LOCK;
        end else if (h_cnt == H_LAST) begin
          h_nxt = '0;
          v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_nxt = h_cnt + 1'b1;
          v_nxt = v_cnt;
        end
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  assign hs_act = (int'(h_cnt) >= HS_BEG) && (int'(h_cnt) < HS_END);
  assign vs_act = (int'(v_cnt) >= VS_BEG) && (int'(v_cnt) < VS_END);
  assign de_act = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);

  // Output register: one cycle behind the counters, idle unless running and still locked.
  always_ff @(posedge clk_25MHz) begin
    if (!resetn || (state != RUN) || !lock_ok) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      hsync       <= hs_act ? HS_POL : ~HS_POL;
      vsync       <= vs_act ? VS_POL : ~VS_POL;
      de          <= de_act;
      x           <= h_cnt;
      y           <= v_cnt;
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      running     <= 1'b1;
    end
  end

endmodule
